pwm_peripheral: RTL and testbench



---
 rtl/pwm_peripheral_pkg.sv | 28 ++
 rtl/pwm_peripheral_if.sv | 10 +
 rtl/pwm_prescaler.sv | 33 +++
 rtl/pwm_peripheral.sv | 140 ++++++++++++++
 tb/tb_pwm_peripheral.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/pwm_peripheral_pkg.sv
// Shared constants for the PWM peripheral: register offsets, CTRL bit layout
// and the 3-bit address-map IDs decoded from addr[31:29].
package pwm_peripheral_pkg;

    typedef enum logic [2:0] {
        OFF_CTRL     = 3'd0,
        OFF_PERIOD   = 3'd1,
        OFF_DUTY     = 3'd2,
        OFF_PRESCALE = 3'd3,
        OFF_COUNT    = 3'd4
    } reg_off_e;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_POL_BIT = 1;

    localparam logic [2:0] ID_RAM  = 3'b000;
    localparam logic [2:0] ID_PWM1 = 3'b001;

    typedef struct packed {
        logic pol;
        logic en;
    } ctrl_t;

    function automatic logic periph_sel(input logic [31:0] addr, input logic [2:0] id);
        return addr[31:29] == id;
    endfunction

endpackage

// File: rtl/pwm_peripheral_if.sv
// Data-memory bus as seen by a memory-mapped peripheral.
interface pwm_peripheral_if;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic        write_enable;
    logic [31:0] data_out;

    modport master (output addr, output data_in, output write_enable, input data_out);
    modport slave  (input addr, input data_in, input write_enable, output data_out);
endinterface

// File: rtl/pwm_prescaler.sv
// Free-running prescale counter; tick fires when the count matches the
// prescale value, so prescale = 0 ticks every cycle.
module pwm_prescaler #(
    parameter int PRE_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic [PRE_WIDTH-1:0] prescale,
    output logic                 tick
);

    logic [PRE_WIDTH-1:0] pre_cnt_reg, pre_cnt_next;

    assign tick = (pre_cnt_reg == prescale);

    // Lowering prescale below the live count simply lets it wrap through 2^PRE_WIDTH.
    always_comb begin
        pre_cnt_next = pre_cnt_reg + 1'b1;
        if (clear || tick) begin
            pre_cnt_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_cnt_reg <= '0;
        end else begin
            pre_cnt_reg <= pre_cnt_next;
        end
    end

endmodule

// File: rtl/pwm_peripheral.sv
// Memory-mapped PWM with double-buffered period/duty, a prescaled counter
// and a registered output pin.
module pwm_peripheral
    import pwm_peripheral_pkg::*;
#(
    parameter int         CNT_WIDTH = 16,
    parameter int         PRE_WIDTH = 8,
    parameter logic [2:0] PERIPH_ID = ID_PWM1
) (
    input  logic              clk,
    input  logic              rst,
    pwm_peripheral_if.slave   bus,
    output logic              pwm_out
);

    logic                 sel;
    logic                 wr_en;
    logic [2:0]           offset;
    logic                 unused_bus;

    ctrl_t                ctrl_reg, ctrl_next;
    logic [CNT_WIDTH-1:0] period_reg, duty_reg;
    logic [PRE_WIDTH-1:0] prescale_reg;

    logic [CNT_WIDTH-1:0] per_a_reg, per_a_next;
    logic [CNT_WIDTH-1:0] duty_a_reg, duty_a_next;
    logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;

    logic                 run;
    logic                 tick;
    logic                 raw;
    logic                 pwm_out_reg;
    logic [31:0]          data_out_reg;
    logic [31:0]          rd_words [8];

    assign sel        = periph_sel(bus.addr, PERIPH_ID);
    assign wr_en      = sel && bus.write_enable;
    assign offset     = bus.addr[4:2];
    assign unused_bus = ^{bus.addr, bus.data_in};

    always_comb begin
        ctrl_next = ctrl_reg;
        if (wr_en && offset == OFF_CTRL) begin
            ctrl_next.en  = bus.data_in[CTRL_EN_BIT];
            ctrl_next.pol = bus.data_in[CTRL_POL_BIT];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_reg     <= '0;
            period_reg   <= '0;
            duty_reg     <= '0;
            prescale_reg <= '0;
        end else begin
            ctrl_reg <= ctrl_next;
            if (wr_en) begin
                case (offset)
                    OFF_PERIOD:   period_reg   <= bus.data_in[CNT_WIDTH-1:0];
                    OFF_DUTY:     duty_reg     <= bus.data_in[CNT_WIDTH-1:0];
                    OFF_PRESCALE: prescale_reg <= bus.data_in[PRE_WIDTH-1:0];
                    default: ;
                endcase
            end
        end
    end

    // Running needs EN both before and after the edge: a 0->1 write starts
    // from cnt = 0 on the next edge, a 1->0 write clears at the same edge.
    assign run = ctrl_reg.en && ctrl_next.en;

    pwm_prescaler #(
        .PRE_WIDTH (PRE_WIDTH)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .clear    (!run),
        .prescale (prescale_reg),
        .tick     (tick)
    );

    always_comb begin
        cnt_next    = cnt_reg;
        per_a_next  = per_a_reg;
        duty_a_next = duty_a_reg;
        if (!run) begin
            cnt_next    = '0;
            per_a_next  = period_reg;
            duty_a_next = duty_reg;
        end else if (tick) begin
            if (cnt_reg >= per_a_reg) begin
                cnt_next    = '0;
                per_a_next  = period_reg;
                duty_a_next = duty_reg;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    assign raw = ctrl_reg.en && (cnt_reg < duty_a_reg);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg     <= '0;
            per_a_reg   <= '0;
            duty_a_reg  <= '0;
            pwm_out_reg <= 1'b0;
        end else begin
            cnt_reg     <= cnt_next;
            per_a_reg   <= per_a_next;
            duty_a_reg  <= duty_a_next;
            pwm_out_reg <= raw ^ ctrl_reg.pol;
        end
    end

    assign rd_words[0] = 32'(ctrl_reg);
    assign rd_words[1] = 32'(period_reg);
    assign rd_words[2] = 32'(duty_reg);
    assign rd_words[3] = 32'(prescale_reg);
    assign rd_words[4] = 32'(cnt_reg);

    generate
        for (genvar gi = 5; gi < 8; gi++) begin : g_reserved
            assign rd_words[gi] = '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out_reg <= '0;
        end else begin
            data_out_reg <= sel ? rd_words[offset] : '0;
        end
    end

    assign bus.data_out = data_out_reg;
    assign pwm_out      = pwm_out_reg;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed bench for pwm_peripheral: register access, waveforms, shadowing,
// boundary duty/period values, address decode and asynchronous reset.
module tb_pwm_peripheral;

    logic clk;
    logic rst;
    logic pwm_out;
    int   pass_cnt;
    int   total_cnt;

    pwm_peripheral_if bus ();

    pwm_peripheral #(
        .CNT_WIDTH (16),
        .PRE_WIDTH (8),
        .PERIPH_ID (3'b001)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .pwm_out (pwm_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] mk_addr(input logic [2:0] id, input logic [2:0] off);
        return {id, 24'hA5A5A5, off, 2'b11};
    endfunction

    task automatic wr_id(input logic [2:0] id, input logic [2:0] off, input logic [31:0] val);
        bus.addr         = mk_addr(id, off);
        bus.data_in      = val;
        bus.write_enable = 1'b1;
        @(negedge clk);
        bus.write_enable = 1'b0;
        $display("wr id=%0d off=%0d val=%0h", id, off, val);
    endtask

    task automatic wr(input logic [2:0] off, input logic [31:0] val);
        wr_id(3'b001, off, val);
    endtask

    task automatic rd_id(input string tag, input logic [2:0] id, input logic [2:0] off,
                         input logic [31:0] exp);
        bus.addr         = mk_addr(id, off);
        bus.write_enable = 1'b0;
        @(negedge clk);
        $display("rd id=%0d off=%0d data=%0h", id, off, bus.data_out);
        chk(tag, bus.data_out, exp);
    endtask

    task automatic rd(input string tag, input logic [2:0] off, input logic [31:0] exp);
        rd_id(tag, 3'b001, off, exp);
    endtask

    task automatic start(input logic [31:0] period, input logic [31:0] duty,
                         input logic [31:0] pre, input logic [31:0] ctrl);
        wr(3'd0, 32'd0);
        wr(3'd1, period);
        wr(3'd2, duty);
        wr(3'd3, pre);
        wr(3'd0, ctrl);
    endtask

    // Sample i reflects the count held after the (i+1)-th edge past enable.
    // Expected high length is h1 before sample sw and h2 from then on.
    task automatic run_wave(input string tag, input int plen, input int h1, input int h2,
                            input int sw, input logic inv, input int n,
                            input int inj_at, input logic [31:0] inj_val);
        logic e;
        for (int i = 0; i < n; i++) begin
            if (i == inj_at) begin
                bus.addr         = mk_addr(3'b001, 3'd2);
                bus.data_in      = inj_val;
                bus.write_enable = 1'b1;
            end else begin
                bus.write_enable = 1'b0;
            end
            @(negedge clk);
            e = ((i % plen) < ((i < sw) ? h1 : h2)) ? 1'b1 : 1'b0;
            e = e ^ inv;
            chk($sformatf("%s[%0d]", tag, i), 32'(pwm_out), 32'(e));
        end
        bus.write_enable = 1'b0;
    endtask

    initial begin
        pass_cnt         = 0;
        total_cnt        = 0;
        bus.addr         = '0;
        bus.data_in      = '0;
        bus.write_enable = 1'b0;
        rst              = 1'b1;
        #1 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_pwm", 32'(pwm_out), 32'd0);
        chk("reset_dout", bus.data_out, 32'd0);
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            rd($sformatf("reset_rd%0d", k), 3'(k), 32'd0);
        end
        chk("reset_pwm_idle", 32'(pwm_out), 32'd0);

        // Basic waveform: 3 high / 7 low, period 10
        start(32'd9, 32'd3, 32'd0, 32'd1);
        run_wave("p0", 10, 3, 3, 0, 1'b0, 25, -1, 32'd0);
        rd("count_rd", 3'd4, 32'd5);
        wr(3'd4, 32'h77);
        rd("count_after_wr", 3'd4, 32'd7);
        wr(3'd6, 32'h1234);
        rd("reserved6", 3'd6, 32'd0);
        rd("ctrl_rd", 3'd0, 32'd1);
        rd("period_rd", 3'd1, 32'd9);

        // Prescale 2: 9 high / 21 low, then inverted polarity
        start(32'd9, 32'd3, 32'd2, 32'd1);
        run_wave("pre2", 30, 9, 9, 0, 1'b0, 60, -1, 32'd0);
        start(32'd9, 32'd3, 32'd2, 32'd3);
        run_wave("pol", 30, 9, 9, 0, 1'b1, 60, -1, 32'd0);
        wr(3'd0, 32'd2);
        @(negedge clk);
        run_wave("dis_pol", 1, 0, 0, 0, 1'b1, 5, -1, 32'd0);
        rd("dis_count", 3'd4, 32'd0);

        // DUTY write mid-period: takes effect at the next wrap
        start(32'd9, 32'd3, 32'd0, 32'd1);
        run_wave("dmid", 10, 3, 6, 10, 1'b0, 30, 5, 32'd6);

        // DUTY write exactly on the wrap edge: old duty for one more period
        start(32'd9, 32'd3, 32'd0, 32'd1);
        run_wave("dwrap", 10, 3, 6, 20, 1'b0, 30, 9, 32'd6);

        // Boundaries
        start(32'd9, 32'd0, 32'd0, 32'd1);
        run_wave("duty0", 10, 0, 0, 0, 1'b0, 20, -1, 32'd0);
        start(32'd9, 32'd12, 32'd0, 32'd1);
        run_wave("duty12", 10, 12, 12, 0, 1'b0, 20, -1, 32'd0);
        start(32'd0, 32'd1, 32'd0, 32'd1);
        run_wave("per0", 1, 1, 1, 0, 1'b0, 20, -1, 32'd0);

        // Address decode
        wr_id(3'b000, 3'd1, 32'd55);
        wr_id(3'b010, 3'd2, 32'd77);
        rd("ram_wr_period", 3'd1, 32'd0);
        rd("oth_wr_duty", 3'd2, 32'd1);
        rd_id("ram_rd", 3'b000, 3'd2, 32'd0);
        rd_id("oth_rd", 3'b010, 3'd2, 32'd0);

        // Read-during-write returns the old value; truncation of write data
        bus.addr = mk_addr(3'b001, 3'd1);
        @(negedge clk);
        wr(3'd1, 32'd20);
        chk("rdw_old", bus.data_out, 32'd0);
        rd("rdw_new", 3'd1, 32'd20);
        wr(3'd3, 32'd5);
        rd("prescale_rd", 3'd3, 32'd5);
        wr(3'd2, 32'h0001_0004);
        rd("duty_trunc", 3'd2, 32'd4);

        // Asynchronous reset mid-run
        start(32'd9, 32'd12, 32'd0, 32'd1);
        rd("pre_rst_period", 3'd1, 32'd9);
        @(negedge clk);
        chk("pre_rst_pwm", 32'(pwm_out), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_pwm", 32'(pwm_out), 32'd0);
        chk("async_rst_dout", bus.data_out, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        rd("post_rst_ctrl", 3'd0, 32'd0);
        rd("post_rst_period", 3'd1, 32'd0);
        chk("post_rst_pwm", 32'(pwm_out), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
